axi4_stream_pkt_arb: RTL

Packet-granular round-robin arbiter that shares one PS AXI4-stream RX channel between N acquisition sources (e.g. scope ch0/ch1, logic analyzer).
- Sits between the stream producers and one srx[] port of the PS wrapper.
- Grants one source at a time and holds the grant until that source's TLAST beat transfers, so packets never interleave.
- Tags each output beat with the source index.

---
 rtl/axi4_stream_pkt_arb_rr_pick.sv | 24 ++
 rtl/axi4_stream_pkt_arb.sv | 72 +++++++
 2 files changed

// File: rtl/axi4_stream_pkt_arb_rr_pick.sv
// rr_pick: combinational round-robin picker returning the first request after the last-served index
module rr_pick #(
  parameter int N = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic          found_o,
  output logic [IW-1:0] idx_o
);
  logic [IW-1:0] k;
  always_comb begin
    found_o = 1'b0;
    idx_o = '0;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(last_i) + i) % N);
      if (req_i[k]) begin
        found_o = 1'b1;
        idx_o = k;
      end
    end
  end
endmodule

// File: rtl/axi4_stream_pkt_arb.sv
// axi4_stream_pkt_arb: packet-granular round-robin merge of N AXI4-stream sources onto one tagged output
module axi4_stream_pkt_arb #(
  parameter int N = 4,
  parameter int DW = 16,
  localparam int IW = $clog2(N),
  localparam int KW = DW / 8
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic [N-1:0]    en_i,
  input  logic [N*DW-1:0] s_tdata_i,
  input  logic [N*KW-1:0] s_tkeep_i,
  input  logic [N-1:0]    s_tlast_i,
  input  logic [N-1:0]    s_tvalid_i,
  output logic [N-1:0]    s_tready_o,
  output logic [DW-1:0]   m_tdata_o,
  output logic [KW-1:0]   m_tkeep_o,
  output logic            m_tlast_o,
  output logic [IW-1:0]   m_tid_o,
  output logic            m_tvalid_o,
  input  logic            m_tready_i,
  output logic            busy_o,
  output logic [IW-1:0]   grant_o
);
  typedef enum logic {IDLE, PKT} state_e;
  state_e state_q, state_d;
  logic [IW-1:0] grant_q, grant_d, last_q, last_d, pick;
  logic found, busy;
  logic [DW-1:0] tdata_a [N];
  logic [KW-1:0] tkeep_a [N];
  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign tdata_a[g] = s_tdata_i[g*DW +: DW];
    assign tkeep_a[g] = s_tkeep_i[g*KW +: KW];
  end
  rr_pick #(.N(N)) u_pick (
    .req_i   (s_tvalid_i & en_i),
    .last_i  (last_q),
    .found_o (found),
    .idx_o   (pick)
  );
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end
  always_comb begin
    busy = state_q == PKT;
    m_tdata_o = busy ? tdata_a[grant_q] : '0;
    m_tkeep_o = busy ? tkeep_a[grant_q] : '0;
    m_tlast_o = busy & s_tlast_i[grant_q];
    m_tvalid_o = busy & s_tvalid_i[grant_q];
    s_tready_o = (busy && m_tready_i) ? N'(1) << grant_q : '0;
    state_d = state_q;
    grant_d = grant_q;
    last_d = last_q;
    if (!busy && found) begin
      state_d = PKT;
      grant_d = pick;
      last_d = pick;
    end
    if (busy && m_tvalid_o && m_tready_i && m_tlast_o) state_d = IDLE;
  end
  assign busy_o = busy;
  assign grant_o = grant_q;
  assign m_tid_o = grant_q;
endmodule
